sdio_cis_reader: RTL and testbench

// - Host-side walker for the SDIO Card Information Structure (the read end of the card's CIA/CIS register space).
// - On i_start, issues single-byte reads from i_cis_ptr and follows the tuple chain (code, link, body).
// - Extracts MANFID (0x20) and FUNCE fn0 (0x22) fields, counts tuples, and reports done or error to the host controller.

---
 rtl/sdio_cis_reader.sv | 210 +++++++++++++++++++++
 tb/tb_sdio_cis_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cis_reader.sv
// Host-side SDIO CIS tuple walker: follows the code/link/body chain, extracts MANFID/FUNCE fn0.
// Optional ack watchdog enabled by defining SDIO_CIS_TIMEOUT_EN.
module sdio_cis_reader #(
    parameter int unsigned MAX_TUPLES = 64
`ifdef SDIO_CIS_TIMEOUT_EN
    ,
    parameter int unsigned ACK_TIMEOUT = 255
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [16:0] i_cis_ptr,
    output logic        o_rd_stb,
    output logic [16:0] o_rd_addr,
    input  logic        i_rd_ack,
    input  logic [7:0]  i_rd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_manf_id,
    output logic [15:0] o_card_id,
    output logic [15:0] o_fn0_blk_size,
    output logic [7:0]  o_tuple_count
);

    localparam logic [17:0] ADDR_MAX = 18'h17FFF;
    localparam logic [7:0]  MAX_CNT  = 8'(MAX_TUPLES);

    typedef enum logic [2:0] {
        StIdle, StRdCode, StRdLink, StRdBody, StSkip, StDone, StErr
    } state_e;

    state_e      state_q;
    logic [17:0] addr_q;
    logic [17:0] body_start_q;
    logic [7:0]  code_q;
    logic [7:0]  link_q;
    logic [1:0]  idx_q;
    logic        funce_ok_q;
    logic [1:0]  err_pend_q;

    logic rd_state;
    logic rd_done;
    logic tmo_hit;

    assign rd_state = (state_q == StRdCode) || (state_q == StRdLink) || (state_q == StRdBody);
    assign rd_done  = o_rd_stb && i_rd_ack;

`ifdef SDIO_CIS_TIMEOUT_EN
    logic [15:0] tmo_q;

    assign tmo_hit = o_rd_stb && !i_rd_ack && (tmo_q == 16'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (o_rd_stb && !i_rd_ack) begin
            tmo_q <= tmo_q + 16'd1;
        end else begin
            tmo_q <= '0;
        end
    end
`else
    // Without the watchdog the walker waits for i_rd_ack indefinitely.
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            body_start_q   <= '0;
            code_q         <= '0;
            link_q         <= '0;
            idx_q          <= '0;
            funce_ok_q     <= 1'b0;
            err_pend_q     <= '0;
            o_rd_stb       <= 1'b0;
            o_rd_addr      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_err_code     <= '0;
            o_manf_id      <= '0;
            o_card_id      <= '0;
            o_fn0_blk_size <= '0;
            o_tuple_count  <= '0;
        end else begin
            o_done <= 1'b0;

            // Issue a read whenever a read state has nothing outstanding; the range check gates it.
            if (rd_state && !o_rd_stb) begin
                if (addr_q > ADDR_MAX) begin
                    err_pend_q <= 2'd2;
                    state_q    <= StErr;
                end else begin
                    o_rd_stb  <= 1'b1;
                    o_rd_addr <= addr_q[16:0];
                end
            end else if (tmo_hit) begin
                o_rd_stb   <= 1'b0;
                err_pend_q <= 2'd1;
                state_q    <= StErr;
            end

            if (rd_done) begin
                o_rd_stb <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        addr_q         <= {1'b0, i_cis_ptr};
                        o_err          <= 1'b0;
                        o_err_code     <= '0;
                        o_tuple_count  <= '0;
                        o_manf_id      <= '0;
                        o_card_id      <= '0;
                        o_fn0_blk_size <= '0;
                        o_busy         <= 1'b1;
                        state_q        <= StRdCode;
                    end
                end
                StRdCode: begin
                    if (rd_done) begin
                        if (i_rd_data == 8'h00) begin
                            addr_q <= addr_q + 18'd1;
                        end else if (i_rd_data == 8'hFF) begin
                            state_q <= StDone;
                        end else if (o_tuple_count == MAX_CNT) begin
                            err_pend_q <= 2'd3;
                            state_q    <= StErr;
                        end else begin
                            code_q        <= i_rd_data;
                            o_tuple_count <= o_tuple_count + 8'd1;
                            addr_q        <= addr_q + 18'd1;
                            state_q       <= StRdLink;
                        end
                    end
                end
                StRdLink: begin
                    if (rd_done) begin
                        if (i_rd_data == 8'hFF) begin
                            state_q <= StDone;
                        end else begin
                            link_q       <= i_rd_data;
                            addr_q       <= addr_q + 18'd1;
                            body_start_q <= addr_q + 18'd1;
                            idx_q        <= '0;
                            funce_ok_q   <= 1'b1;
                            if ((code_q == 8'h20 && i_rd_data >= 8'd4) ||
                                (code_q == 8'h22 && i_rd_data >= 8'd3)) begin
                                state_q <= StRdBody;
                            end else begin
                                state_q <= StSkip;
                            end
                        end
                    end
                end
                StRdBody: begin
                    if (rd_done) begin
                        addr_q <= addr_q + 18'd1;
                        idx_q  <= idx_q + 2'd1;
                        if (code_q == 8'h20) begin
                            case (idx_q)
                                2'd0:    o_manf_id[7:0]  <= i_rd_data;
                                2'd1:    o_manf_id[15:8] <= i_rd_data;
                                2'd2:    o_card_id[7:0]  <= i_rd_data;
                                default: o_card_id[15:8] <= i_rd_data;
                            endcase
                            if (idx_q == 2'd3) begin
                                state_q <= StSkip;
                            end
                        end else begin
                            // Only FUNCE type 0x00 (function 0 extension) carries the block size.
                            case (idx_q)
                                2'd0: funce_ok_q <= (i_rd_data == 8'h00);
                                2'd1: if (funce_ok_q) o_fn0_blk_size[7:0] <= i_rd_data;
                                default: if (funce_ok_q) o_fn0_blk_size[15:8] <= i_rd_data;
                            endcase
                            if (idx_q == 2'd2) begin
                                state_q <= StSkip;
                            end
                        end
                    end
                end
                StSkip: begin
                    addr_q  <= body_start_q + {10'b0, link_q};
                    state_q <= StRdCode;
                end
                StDone: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                StErr: begin
                    o_err      <= 1'b1;
                    o_err_code <= err_pend_q;
                    o_done     <= 1'b1;
                    o_busy     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_cis_reader.sv
// Directed bench for sdio_cis_reader: a table of CIS images plus hand sequences for the
// tuple limit, mid-walk start, mid-walk reset and (when SDIO_CIS_TIMEOUT_EN) the ack watchdog.
module tb_sdio_cis_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [16:0] i_cis_ptr;
    logic        o_rd_stb;
    logic [16:0] o_rd_addr;
    logic        i_rd_ack;
    logic [7:0]  i_rd_data;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic [15:0] o_manf_id;
    logic [15:0] o_card_id;
    logic [15:0] o_fn0_blk_size;
    logic [7:0]  o_tuple_count;

    always #5 clk = ~clk;

`ifdef SDIO_CIS_TIMEOUT_EN
    sdio_cis_reader #(.MAX_TUPLES(64), .ACK_TIMEOUT(16)) dut (
`else
    sdio_cis_reader #(.MAX_TUPLES(64)) dut (
`endif
        .clk(clk), .rst(rst), .i_start(i_start), .i_cis_ptr(i_cis_ptr),
        .o_rd_stb(o_rd_stb), .o_rd_addr(o_rd_addr), .i_rd_ack(i_rd_ack),
        .i_rd_data(i_rd_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_err_code(o_err_code), .o_manf_id(o_manf_id), .o_card_id(o_card_id),
        .o_fn0_blk_size(o_fn0_blk_size), .o_tuple_count(o_tuple_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Card memory model; unmapped bytes read back as 0xFF.
    logic [7:0] mem [int];

    function automatic logic [7:0] mem_rd(input logic [16:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 8'hFF;
    endfunction

    task automatic load(input logic [16:0] base, input logic [127:0] img, input int len);
        mem.delete();
        for (int i = 0; i < len; i++) begin
            mem[int'(base) + i] = img[8*(len-1-i) +: 8];
        end
    endtask

    // Read responder: acks after ack_lat stalled cycles, then checks the strobe drops.
    int          ack_lat  = 0;
    bit          ack_en   = 1'b1;
    int          n_reads  = 0;
    int          wait_cnt = 0;

    initial begin
        i_rd_ack  = 1'b0;
        i_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (i_rd_ack) begin
                i_rd_ack = 1'b0;
                check("stb_drop_after_ack", 32'(o_rd_stb), 32'd0);
            end else if (ack_en && o_rd_stb) begin
                if (wait_cnt >= ack_lat) begin
                    i_rd_ack  = 1'b1;
                    i_rd_data = mem_rd(o_rd_addr);
                    n_reads++;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run(input logic [16:0] ptr, input int budget, output bit ok);
        @(negedge clk);
        n_reads   = 0;
        i_cis_ptr = ptr;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(budget, ok);
    endtask

    typedef struct {
        logic [16:0]  ptr;
        logic [127:0] img;
        int           len;
        logic [15:0]  manf;
        logic [15:0]  card;
        logic [15:0]  blk;
        logic [7:0]   cnt;
        logic         err;
        logic [1:0]   code;
        int           reads;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int hi;
        logic any;

        vecs[0] = '{17'h01000, 128'({8'h20, 8'h04, 8'h96, 8'h02, 8'h11, 8'h50, 8'hFF}), 7,
                    16'h0296, 16'h5011, 16'h0000, 8'd1, 1'b0, 2'd0, 7};
        vecs[1] = '{17'h02000, 128'({8'h21, 8'h02, 8'h0C, 8'h00, 8'h22, 8'h04, 8'h00, 8'h00,
                    8'h02, 8'h32, 8'hFF}), 11, 16'h0000, 16'h0000, 16'h0200, 8'd2, 1'b0, 2'd0, 8};
        vecs[2] = '{17'h02000, 128'({8'h21, 8'h02, 8'h0C, 8'h00, 8'h22, 8'h04, 8'h00, 8'h00,
                    8'h02, 8'h32, 8'h00, 8'hFF}), 12, 16'h0000, 16'h0000, 16'h0200, 8'd2, 1'b0,
                    2'd0, 9};
        vecs[3] = '{17'h17FFE, 128'({8'h91, 8'h05}), 2,
                    16'h0000, 16'h0000, 16'h0000, 8'd1, 1'b1, 2'd2, 2};
        vecs[4] = '{17'h03000, 128'({8'h15, 8'hFF}), 2,
                    16'h0000, 16'h0000, 16'h0000, 8'd1, 1'b0, 2'd0, 2};
        vecs[5] = '{17'h04000, 128'({8'h22, 8'h03, 8'h01, 8'h34, 8'h12, 8'hFF}), 6,
                    16'h0000, 16'h0000, 16'h0000, 8'd1, 1'b0, 2'd0, 6};
        vecs[6] = '{17'h06000, 128'({8'h20, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h20, 8'h05,
                    8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hFF}), 14,
                    16'h6655, 16'h8877, 16'h0000, 8'd2, 1'b0, 2'd0, 13};
        vecs[7] = '{17'h07000, 128'({8'h20, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hFF}), 6,
                    16'h0000, 16'h0000, 16'h0000, 8'd1, 1'b0, 2'd0, 3};
        vecs[8] = '{17'h1FFFF, 128'h0, 0,
                    16'h0000, 16'h0000, 16'h0000, 8'd0, 1'b1, 2'd2, 0};
        vecs[9] = '{17'h08000, 128'({8'hFF}), 1,
                    16'h0000, 16'h0000, 16'h0000, 8'd0, 1'b0, 2'd0, 1};

        rst       = 1'b1;
        i_start   = 1'b0;
        i_cis_ptr = '0;
        repeat (3) @(negedge clk);
        any = |{o_rd_stb, o_rd_addr, o_busy, o_done, o_err, o_err_code, o_manf_id, o_card_id,
                o_fn0_blk_size, o_tuple_count};
        check("reset_outputs_zero", 32'(any), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            load(vecs[i].ptr, vecs[i].img, vecs[i].len);
            ack_lat = i % 3;
            run(vecs[i].ptr, 400, ok);
            check($sformatf("v%0d_done", i), 32'(ok), 32'd1);
            check($sformatf("v%0d_err", i), 32'(o_err), 32'(vecs[i].err));
            check($sformatf("v%0d_code", i), 32'(o_err_code), 32'(vecs[i].code));
            check($sformatf("v%0d_manf", i), 32'(o_manf_id), 32'(vecs[i].manf));
            check($sformatf("v%0d_card", i), 32'(o_card_id), 32'(vecs[i].card));
            check($sformatf("v%0d_blk", i), 32'(o_fn0_blk_size), 32'(vecs[i].blk));
            check($sformatf("v%0d_count", i), 32'(o_tuple_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_reads", i), n_reads, vecs[i].reads);
            check($sformatf("v%0d_busy_at_done", i), 32'(o_busy), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), 32'(o_done), 32'd0);
        end

        // Tuple limit: 65 tuples overflow, 64 tuples are still legal.
        ack_lat = 0;
        mem.delete();
        for (int k = 0; k < 65; k++) begin
            mem[32'h5000 + 2*k]     = 8'h80;
            mem[32'h5000 + 2*k + 1] = 8'h00;
        end
        mem[32'h5000 + 130] = 8'hFF;
        run(17'h05000, 3000, ok);
        check("lim65_done", 32'(ok), 32'd1);
        check("lim65_err", 32'(o_err), 32'd1);
        check("lim65_code", 32'(o_err_code), 32'd3);
        check("lim65_count", 32'(o_tuple_count), 32'd64);
        mem[32'h5000 + 128] = 8'hFF;
        run(17'h05000, 3000, ok);
        check("lim64_done", 32'(ok), 32'd1);
        check("lim64_err", 32'(o_err), 32'd0);
        check("lim64_count", 32'(o_tuple_count), 32'd64);

        // i_start while busy must not restart the walk.
        load(17'h01000, vecs[0].img, vecs[0].len);
        ack_lat = 2;
        @(negedge clk);
        i_cis_ptr = 17'h01000;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
        repeat (6) @(negedge clk);
        i_cis_ptr = 17'h03000;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(400, ok);
        check("midstart_done", 32'(ok), 32'd1);
        check("midstart_manf", 32'(o_manf_id), 32'h0296);
        check("midstart_card", 32'(o_card_id), 32'h5011);
        check("midstart_count", 32'(o_tuple_count), 32'd1);

        // Reset mid-walk: outputs clear at once and no o_done appears.
        @(negedge clk);
        i_cis_ptr = 17'h01000;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        any = |{o_rd_stb, o_rd_addr, o_busy, o_done, o_err, o_err_code, o_manf_id, o_card_id,
                o_fn0_blk_size, o_tuple_count};
        check("midrst_outputs_zero", 32'(any), 32'd0);
        any = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            any = any | o_done | o_busy | o_rd_stb;
        end
        check("midrst_stays_idle", 32'(any), 32'd0);

`ifdef SDIO_CIS_TIMEOUT_EN
        ack_en = 1'b0;
        hi     = 0;
        @(negedge clk);
        i_cis_ptr = 17'h01000;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        ok      = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_rd_stb) hi++;
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("tmo_done", 32'(ok), 32'd1);
        check("tmo_stb_cycles", hi, 16);
        check("tmo_err", 32'(o_err), 32'd1);
        check("tmo_code", 32'(o_err_code), 32'd1);
        ack_en = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
